// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Instruction fetch/sequence controller. Fetches a 16-bit instruction from
//   IDLE when run is high, then walks the control states for that opcode and
//   advances or loads the program counter when the instruction completes.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   run        in   permits a fetch from IDLE
//   instr      in   16-bit instruction word at address pc
//   count      in   register index from the external counter (onesAll loop)
//   branchAddr in   branch target from the bus
//   state      out  5-bit control state code for the decoder
//   fncode     out  latched instruction register
//   pc         out  program counter / instruction address
//   busy       out  high whenever state is not IDLE
//   halted     out  high while in HALT
module instr_sequencer #(
    parameter int         PC_W     = 8,
    parameter logic [3:0] LAST_REG = 4'd7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [15:0]     instr,
    input  logic [3:0]      count,
    input  logic [PC_W-1:0] branchAddr,
    output logic [4:0]      state,
    output logic [15:0]     fncode,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    localparam logic [4:0] ST_IDLE   = 5'b00000;
    localparam logic [4:0] ST_LOAD   = 5'b00001;
    localparam logic [4:0] ST_MOVE   = 5'b00010;
    localparam logic [4:0] ST_LDPC   = 5'b00011;
    localparam logic [4:0] ST_BRANCH = 5'b00100;
    localparam logic [4:0] ST_ADD0   = 5'b00101;
    localparam logic [4:0] ST_ADD1   = 5'b00110;
    localparam logic [4:0] ST_ADD2   = 5'b00111;
    localparam logic [4:0] ST_XOR0   = 5'b01000;
    localparam logic [4:0] ST_XOR1   = 5'b01001;
    localparam logic [4:0] ST_XOR2   = 5'b01010;
    localparam logic [4:0] ST_SUB0   = 5'b01011;
    localparam logic [4:0] ST_SUB1   = 5'b01100;
    localparam logic [4:0] ST_SUB2   = 5'b01101;
    localparam logic [4:0] ST_MUL0   = 5'b01110;
    localparam logic [4:0] ST_MUL1   = 5'b01111;
    localparam logic [4:0] ST_MUL2   = 5'b10000;
    localparam logic [4:0] ST_DIV0   = 5'b10001;
    localparam logic [4:0] ST_DIV1   = 5'b10010;
    localparam logic [4:0] ST_DIV2   = 5'b10011;
    localparam logic [4:0] ST_ONE0   = 5'b10100;
    localparam logic [4:0] ST_ONE1   = 5'b10101;
    localparam logic [4:0] ST_ONE2   = 5'b10110;
    localparam logic [4:0] ST_OA0    = 5'b10111;
    localparam logic [4:0] ST_OA1    = 5'b11000;
    localparam logic [4:0] ST_OA2    = 5'b11001;
    localparam logic [4:0] ST_OA3    = 5'b11010;
    localparam logic [4:0] ST_OA4    = 5'b11011;
    localparam logic [4:0] ST_OA5    = 5'b11100;
    localparam logic [4:0] ST_OA6    = 5'b11101;
    localparam logic [4:0] ST_HALT   = 5'b11110;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [4:0]      state_r;
    logic [15:0]     fncode_r;
    logic [PC_W-1:0] pc_r;
    logic            busy_r;
    logic            halted_r;

    logic [4:0]      state_nxt_s;
    logic [15:0]     fncode_nxt_s;
    logic [PC_W-1:0] pc_nxt_s;

    // Next-state, next-pc and instruction-latch decode.
    always_comb begin
        state_nxt_s  = state_r;
        fncode_nxt_s = fncode_r;
        pc_nxt_s     = pc_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    fncode_nxt_s = instr;
                    case (instr[15:12])
                        4'h0:    state_nxt_s = ST_LOAD;
                        4'h1:    state_nxt_s = ST_MOVE;
                        4'h2:    state_nxt_s = ST_LDPC;
                        4'h3:    state_nxt_s = ST_BRANCH;
                        4'h4:    state_nxt_s = ST_ADD0;
                        4'h5:    state_nxt_s = ST_XOR0;
                        4'h6:    state_nxt_s = ST_SUB0;
                        4'h7:    state_nxt_s = ST_MUL0;
                        4'h8:    state_nxt_s = ST_DIV0;
                        4'h9:    state_nxt_s = ST_ONE0;
                        4'hA:    state_nxt_s = ST_OA0;
                        4'hF:    state_nxt_s = ST_HALT;
                        default: begin
                            // Illegal opcode behaves as a NOP: skip it without leaving IDLE.
                            state_nxt_s = ST_IDLE;
                            pc_nxt_s    = pc_r + PC_ONE;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            // Terminal states: instruction done, advance to the next address.
            ST_LOAD, ST_MOVE, ST_LDPC, ST_ADD2, ST_XOR2, ST_SUB2,
            ST_MUL2, ST_DIV2, ST_ONE2, ST_OA6: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = pc_r + PC_ONE;
            end
            ST_BRANCH: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = branchAddr;
            end
            // Intermediate states of the multi-cycle ops are numbered consecutively.
            ST_ADD0, ST_ADD1, ST_XOR0, ST_XOR1, ST_SUB0, ST_SUB1,
            ST_MUL0, ST_MUL1, ST_DIV0, ST_DIV1, ST_ONE0, ST_ONE1,
            ST_OA0, ST_OA1, ST_OA2, ST_OA3, ST_OA4: begin
                state_nxt_s = state_r + 5'd1;
            end
            ST_OA5: begin
                // Loop over registers until the external counter reaches the last one.
                if (count == LAST_REG) begin
                    state_nxt_s = ST_OA6;
                end else begin
                    state_nxt_s = ST_OA2;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                // Unused code: recover to IDLE without touching pc.
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, instruction register, pc and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            fncode_r <= 16'h0000;
            pc_r     <= {PC_W{1'b0}};
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            fncode_r <= fncode_nxt_s;
            pc_r     <= pc_nxt_s;
            // Flags are registered from the next state so they track state exactly.
            busy_r   <= (state_nxt_s != ST_IDLE);
            halted_r <= (state_nxt_s == ST_HALT);
        end
    end

    assign state  = state_r;
    assign fncode = fncode_r;
    assign pc     = pc_r;
    assign busy   = busy_r;
    assign halted = halted_r;

endmodule
